// File: rtl/ifetch_pc_unit_pkg.sv
// Shared types and constants for the instruction-fetch PC unit.
// Holds the fetch FSM state encoding and the branch-take decision.
package ifetch_pc_unit_pkg;

    localparam int WORD_W      = 64;
    localparam int INSTR_WIDTH = 32;
    localparam int PC_STEP     = 4;

    typedef enum logic [1:0] {
        FETCH_REQ   = 2'd0,
        FETCH_WAIT  = 2'd1,
        FETCH_DRAIN = 2'd2,
        FETCH_HOLD  = 2'd3
    } fetch_state_e;

    // ex_zero only qualifies CBZ; an unconditional B is always taken
    function automatic logic branch_taken(input logic uncond, input logic cbz, input logic zero);
        return uncond | (cbz & zero);
    endfunction

endpackage

// File: rtl/ifetch_pc_unit_if.sv
// Instruction-memory read channel: one request/address toward memory,
// ready/rvalid/rdata back.
interface ifetch_pc_unit_if
    import ifetch_pc_unit_pkg::*;
    #(parameter int WORD = WORD_W, parameter int INSTR_W = INSTR_WIDTH) ();

    logic               req;
    logic [WORD-1:0]    addr;
    logic               ready;
    logic               rvalid;
    logic [INSTR_W-1:0] rdata;

    modport master (output req, output addr, input ready, input rvalid, input rdata);
    modport slave  (input req, input addr, output ready, output rvalid, output rdata);

endinterface

// File: rtl/ifetch_pc_unit_skid.sv
// One-entry holding register for an instruction and its PC+4 while decode
// is stalled. Clear wins over load, load wins over unload.
module ifetch_pc_unit_skid
    import ifetch_pc_unit_pkg::*;
#(
    parameter int WORD    = WORD_W,
    parameter int INSTR_W = INSTR_WIDTH
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic               unload,
    input  logic               clear,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [WORD-1:0]    load_npc,
    output logic               full,
    output logic [INSTR_W-1:0] instr,
    output logic [WORD-1:0]    npc
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full  <= 1'b0;
            instr <= '0;
            npc   <= '0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            full  <= 1'b1;
            instr <= load_instr;
            npc   <= load_npc;
        end else if (unload) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/ifetch_pc_unit.sv
// Fetch-side PC owner: issues one outstanding imem read at a time, hands
// instruction + PC+4 to decode, and redirects on execute's branch resolution.
module ifetch_pc_unit
    import ifetch_pc_unit_pkg::*;
#(
    parameter int              WORD     = WORD_W,
    parameter int              INSTR_W  = INSTR_WIDTH,
    parameter logic [WORD-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               stall,
    input  logic               ex_uncond,
    input  logic               ex_cbz,
    input  logic               ex_zero,
    input  logic [WORD-1:0]    ex_branch_target,
    ifetch_pc_unit_if.master   imem,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [WORD-1:0]    if_npc,
    output logic               flush,
    output logic               misalign
);

    fetch_state_e       state;
    logic [WORD-1:0]    pc;
    logic [WORD-1:0]    fpc;
    logic [WORD-1:0]    fpc_next;
    logic [WORD-1:0]    target_aligned;
    logic               take;
    logic               accept;
    logic               outstanding;
    logic               skid_load;
    logic               skid_unload;
    logic               skid_full;
    logic [INSTR_W-1:0] skid_instr;
    logic [WORD-1:0]    skid_npc;

    assign take           = branch_taken(ex_uncond, ex_cbz, ex_zero);
    assign imem.req       = reset_n & (state == FETCH_REQ) & ~stall & ~take;
    assign imem.addr      = pc;
    assign accept         = imem.req & imem.ready;
    assign fpc_next       = fpc + WORD'(PC_STEP);
    assign target_aligned = {ex_branch_target[WORD-1:2], 2'b00};

    // A response landing in the redirect cycle is consumed there, so only
    // an unanswered request needs draining.
    assign outstanding = ((state == FETCH_WAIT) | (state == FETCH_DRAIN)) & ~imem.rvalid;

    assign skid_load   = (state == FETCH_WAIT) & imem.rvalid & stall & ~take;
    assign skid_unload = (state == FETCH_HOLD) & ~stall & ~take;

    ifetch_pc_unit_skid #(
        .WORD    (WORD),
        .INSTR_W (INSTR_W)
    ) u_skid (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (skid_load),
        .unload     (skid_unload),
        .clear      (take),
        .load_instr (imem.rdata),
        .load_npc   (fpc_next),
        .full       (skid_full),
        .instr      (skid_instr),
        .npc        (skid_npc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= FETCH_REQ;
            pc       <= RESET_PC;
            fpc      <= RESET_PC;
            if_valid <= 1'b0;
            if_instr <= '0;
            if_npc   <= '0;
            flush    <= 1'b0;
            misalign <= 1'b0;
        end else begin
            flush <= take;
            if (take) begin
                pc       <= target_aligned;
                if_valid <= 1'b0;
                state    <= outstanding ? FETCH_DRAIN : FETCH_REQ;
                if (ex_branch_target[1:0] != 2'b00) begin
                    misalign <= 1'b1;
                end
            end else begin
                // outputs are frozen under stall; otherwise a bubble unless refilled below
                if (!stall) begin
                    if_valid <= 1'b0;
                end
                case (state)
                    FETCH_REQ: begin
                        if (accept) begin
                            fpc   <= pc;
                            state <= FETCH_WAIT;
                        end
                    end
                    FETCH_WAIT: begin
                        if (imem.rvalid) begin
                            pc <= fpc_next;
                            if (stall) begin
                                state <= FETCH_HOLD;
                            end else begin
                                if_valid <= 1'b1;
                                if_instr <= imem.rdata;
                                if_npc   <= fpc_next;
                                state    <= FETCH_REQ;
                            end
                        end
                    end
                    FETCH_HOLD: begin
                        if (!stall) begin
                            if_valid <= skid_full;
                            if_instr <= skid_instr;
                            if_npc   <= skid_npc;
                            state    <= FETCH_REQ;
                        end
                    end
                    FETCH_DRAIN: begin
                        if (imem.rvalid) begin
                            state <= FETCH_REQ;
                        end
                    end
                    default: state <= FETCH_REQ;
                endcase
            end
        end
    end

endmodule
